// File: rtl/pkt_serial_tx_if.sv
// Descriptor, byte-stream and port request/serial signals of pkt_serial_tx.
// master is the frame source / arbiter side, slave is the transmitter.
interface pkt_serial_tx_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 8
);
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [7:0]        clk_freq;
  logic [LEN_W-1:0]  data_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              req;
  logic              gnt;
  logic              dout;
  logic              busy;
  logic              done;
  logic              abort;

  modport master (
    output start_valid, src_addr, dest_addr, clk_freq, data_len, byte_valid, byte_data, gnt,
    input  start_ready, byte_ready, req, dout, busy, done, abort
  );

  modport slave (
    input  start_valid, src_addr, dest_addr, clk_freq, data_len, byte_valid, byte_data, gnt,
    output start_ready, byte_ready, req, dout, busy, done, abort
  );
endinterface

// File: rtl/pkt_serial_tx.sv
// Serial packet transmitter: wins the port via req/gnt, then shifts preamble, header,
// payload and CRC-16/CCITT-FALSE out MSB-first, one bit per core_clock.
module pkt_serial_tx #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  PREAMBLE = 8'hFE,
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input logic            core_clock,
  input logic            core_rst,
  pkt_serial_tx_if.slave bus
);
  localparam int unsigned SW0 = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int unsigned SW  = (SW0 > 16) ? SW0 : 16;
  localparam int unsigned CW  = $clog2(SW);

  typedef enum logic [3:0] {
    StIdle, StReq, StPre, StSrc, StDst, StFrq, StLen, StData, StCrc
  } state_e;

  state_e            state_q;
  logic              start_ready_q, req_q, busy_q, dout_q, done_q, abort_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [7:0]        frq_q;
  logic [LEN_W-1:0]  len_q, fetched_q, sent_q;
  logic [7:0]        hold_q;
  logic              hold_full_q;
  logic [SW-1:0]     sh_q;
  logic [CW-1:0]     rem_q;
  logic [15:0]       crc_q;

  state_e        nxt_st, drv_st;
  logic [SW-1:0] nxt_val, sh_d;
  logic [CW-1:0] nxt_rem, rem_d;
  logic          fld_end, need_byte, underrun, grant_loss, finish, drv_bit, byte_ready;
  logic [15:0]   crc_upd;

  // Field values are left-aligned in the shifter so the next bit is always sh_q[SW-1].
  always_comb begin
    fld_end   = (rem_q == '0);
    need_byte = (sent_q < len_q);
    nxt_st    = StIdle;
    nxt_val   = '0;
    nxt_rem   = '0;
    unique case (state_q)
      StReq: begin
        nxt_st  = StPre;
        nxt_val = SW'(PREAMBLE) << (SW - 8);
        nxt_rem = CW'(7);
      end
      StPre: begin
        nxt_st  = StSrc;
        nxt_val = SW'(src_q) << (SW - ADDR_W);
        nxt_rem = CW'(ADDR_W - 1);
      end
      StSrc: begin
        nxt_st  = StDst;
        nxt_val = SW'(dst_q) << (SW - ADDR_W);
        nxt_rem = CW'(ADDR_W - 1);
      end
      StDst: begin
        nxt_st  = StFrq;
        nxt_val = SW'(frq_q) << (SW - 8);
        nxt_rem = CW'(7);
      end
      StFrq: begin
        nxt_st  = StLen;
        nxt_val = SW'(len_q) << (SW - LEN_W);
        nxt_rem = CW'(LEN_W - 1);
      end
      StLen, StData: begin
        if (need_byte) begin
          nxt_st  = StData;
          nxt_val = SW'(hold_q) << (SW - 8);
          nxt_rem = CW'(7);
        end else begin
          nxt_st  = StCrc;
          nxt_val = SW'(crc_q) << (SW - 16);
          nxt_rem = CW'(15);
        end
      end
      default: ;
    endcase

    if (fld_end) begin
      drv_st  = nxt_st;
      drv_bit = nxt_val[SW-1];
      sh_d    = nxt_val << 1;
      rem_d   = nxt_rem;
    end else begin
      drv_st  = state_q;
      drv_bit = sh_q[SW-1];
      sh_d    = sh_q << 1;
      rem_d   = rem_q - CW'(1);
    end

    underrun   = fld_end && (state_q inside {StLen, StData}) && need_byte && !hold_full_q;
    grant_loss = (state_q inside {StPre, StSrc, StDst, StFrq, StLen, StData, StCrc}) &&
                 !bus.gnt;
    finish     = (state_q == StCrc) && fld_end;
    crc_upd    = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ drv_bit) ? CRC_POLY : 16'h0000);
    byte_ready = !hold_full_q && (fetched_q < len_q) &&
                 (state_q inside {StPre, StSrc, StDst, StFrq, StLen, StData});
  end

  always_ff @(posedge core_clock) begin
    if (core_rst) begin
      state_q       <= StIdle;
      start_ready_q <= 1'b0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      dout_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      frq_q         <= '0;
      len_q         <= '0;
      fetched_q     <= '0;
      sent_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sh_q          <= '0;
      rem_q         <= '0;
      crc_q         <= CRC_INIT;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (bus.byte_valid && byte_ready) begin
        hold_q      <= bus.byte_data;
        hold_full_q <= 1'b1;
        fetched_q   <= fetched_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          start_ready_q <= 1'b1;
          if (bus.start_valid && start_ready_q) begin
            src_q         <= bus.src_addr;
            dst_q         <= bus.dest_addr;
            frq_q         <= bus.clk_freq;
            len_q         <= bus.data_len;
            state_q       <= StReq;
            start_ready_q <= 1'b0;
            req_q         <= 1'b1;
            busy_q        <= 1'b1;
            crc_q         <= CRC_INIT;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            fetched_q     <= '0;
            sent_q        <= '0;
            rem_q         <= '0;
          end
        end
        StReq: begin
          if (bus.gnt) begin
            state_q <= StPre;
            dout_q  <= drv_bit;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
          end
        end
        default: begin
          if (grant_loss || underrun || finish) begin
            // Abort wins over completion so the two pulses can never coincide.
            state_q       <= StIdle;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            dout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            hold_full_q   <= 1'b0;
            abort_q       <= grant_loss || underrun;
            done_q        <= !(grant_loss || underrun);
          end else begin
            state_q <= drv_st;
            dout_q  <= drv_bit;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            if (drv_st inside {StSrc, StDst, StFrq, StLen, StData}) begin
              crc_q <= crc_upd;
            end
            if (fld_end && (drv_st == StData)) begin
              hold_full_q <= 1'b0;
              sent_q      <= sent_q + LEN_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.byte_ready  = byte_ready;
  assign bus.req         = req_q;
  assign bus.dout        = dout_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.abort       = abort_q;
endmodule
